// File: rtl/usb_rx_packet_decoder.sv
// usb_rx_packet_decoder
//  Receive path for a USB D+/D- pair sampled once per clock (one line symbol
//  per clock). Hunts for SYNC, NRZI-decodes, removes stuff bits, detects EOP
//  and bus reset, and delivers LSB-first bytes with a last-byte marker.
//  Line/protocol errors raise a one-cycle strobe with a code so the upper
//  layer can drop the packet.
//
// Ports
//  clock          sample/bit clock, rising edge
//  reset_n        asynchronous active-low reset
//  J_state        line encoding of J for the current speed
//  K_state        line encoding of K for the current speed
//  usb_signals    {D+,D-} as sampled; SE0=2'b00, SE1=2'b11
//  rx_enable      low: decoder held in IDLE (bus driven locally)
//  data_out       received byte, bit 0 = first bit on the wire
//  data_out_val   one-cycle strobe, data_out valid
//  data_out_last  with data_out_val: final byte of the packet
//  rx_active      high from SYNC accept until EOP/abort/error
//  rx_error       one-cycle strobe, error_code valid
//  error_code     0 stuff, 1 SE1, 2 alignment/EOP, 3 babble
//  bus_reset_det  one-cycle strobe on the RESET_CYCLES-th consecutive SE0
module usb_rx_packet_decoder #(
  parameter int RESET_CYCLES = 16,
  parameter int IDLE_CYCLES  = 7,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] J_state,
  input  logic [1:0] K_state,
  input  logic [1:0] usb_signals,
  input  logic       rx_enable,
  output logic [7:0] data_out,
  output logic       data_out_val,
  output logic       data_out_last,
  output logic       rx_active,
  output logic       rx_error,
  output logic [1:0] error_code,
  output logic       bus_reset_det
);

  localparam int SE0_W  = $clog2(RESET_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int BYTE_W = $clog2(MAX_BYTES + 1);

  localparam logic [SE0_W-1:0]  SE0_SAT   = SE0_W'(RESET_CYCLES);
  localparam logic [SE0_W-1:0]  SE0_LAST  = SE0_W'(RESET_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [BYTE_W-1:0] BYTE_MAX  = BYTE_W'(MAX_BYTES);

  // Symbol classes kept in the line history
  localparam logic [1:0] C_SE0 = 2'd0;
  localparam logic [1:0] C_J   = 2'd1;
  localparam logic [1:0] C_K   = 2'd2;
  localparam logic [1:0] C_BAD = 2'd3;   // SE1 or any non-J/K code

  // K J K J K J K K, oldest symbol in the most significant position
  localparam logic [15:0] SYNC_PAT = {C_K, C_J, C_K, C_J, C_K, C_J, C_K, C_K};

  localparam logic [1:0] ERR_STUFF  = 2'd0;
  localparam logic [1:0] ERR_SE1    = 2'd1;
  localparam logic [1:0] ERR_ALIGN  = 2'd2;
  localparam logic [1:0] ERR_BABBLE = 2'd3;

  // The SYNC hunt lives in IDLE as a match on the symbol history.
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOP, S_ERROR} state_t;

  state_t             state, state_next;
  logic [13:0]        hist;
  logic [15:0]        hist_next;
  logic [SE0_W-1:0]   se0_cnt, se0_cnt_next;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_next;
  logic               prev_k, prev_k_next;
  logic [2:0]         ones, ones_next;
  logic [2:0]         bit_cnt, bit_cnt_next;
  logic [7:0]         shift, shift_next;
  logic [7:0]         held, held_next;
  logic               held_valid, held_valid_next;
  logic [BYTE_W-1:0]  byte_cnt, byte_cnt_next;
  logic [1:0]         eop_cnt, eop_cnt_next;
  logic               pend_err, pend_err_next;
  logic [7:0]         data_out_next;
  logic               val_next, last_next, active_next, err_next, bus_reset_next;
  logic [1:0]         code_next;

  logic [1:0]         cls;
  logic               rx_bit;
  logic [7:0]         new_byte;
  logic               reset_hit;
  logic               go_err;
  logic [1:0]         go_code;

  always_comb begin
    if (usb_signals == 2'b00)         cls = C_SE0;
    else if (usb_signals == 2'b11)    cls = C_BAD;
    else if (usb_signals == J_state)  cls = C_J;
    else if (usb_signals == K_state)  cls = C_K;
    else                              cls = C_BAD;
  end

  // NRZI: no transition is a one
  assign rx_bit    = ((cls == C_K) == prev_k);
  assign new_byte  = {rx_bit, shift[7:1]};
  assign reset_hit = (cls == C_SE0) && (se0_cnt == SE0_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      hist          <= '0;
      se0_cnt       <= '0;
      idle_cnt      <= '0;
      prev_k        <= 1'b0;
      ones          <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      held          <= '0;
      held_valid    <= 1'b0;
      byte_cnt      <= '0;
      eop_cnt       <= '0;
      pend_err      <= 1'b0;
      data_out      <= '0;
      data_out_val  <= 1'b0;
      data_out_last <= 1'b0;
      rx_active     <= 1'b0;
      rx_error      <= 1'b0;
      error_code    <= '0;
      bus_reset_det <= 1'b0;
    end else begin
      state         <= state_next;
      hist          <= hist_next[13:0];
      se0_cnt       <= se0_cnt_next;
      idle_cnt      <= idle_cnt_next;
      prev_k        <= prev_k_next;
      ones          <= ones_next;
      bit_cnt       <= bit_cnt_next;
      shift         <= shift_next;
      held          <= held_next;
      held_valid    <= held_valid_next;
      byte_cnt      <= byte_cnt_next;
      eop_cnt       <= eop_cnt_next;
      pend_err      <= pend_err_next;
      data_out      <= data_out_next;
      data_out_val  <= val_next;
      data_out_last <= last_next;
      rx_active     <= active_next;
      rx_error      <= err_next;
      error_code    <= code_next;
      bus_reset_det <= bus_reset_next;
    end
  end

  always_comb begin
    state_next      = state;
    hist_next       = {hist, cls};
    idle_cnt_next   = idle_cnt;
    prev_k_next     = prev_k;
    ones_next       = ones;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift;
    held_next       = held;
    held_valid_next = held_valid;
    byte_cnt_next   = byte_cnt;
    eop_cnt_next    = eop_cnt;
    pend_err_next   = pend_err;
    data_out_next   = data_out;
    val_next        = 1'b0;
    last_next       = 1'b0;
    err_next        = 1'b0;
    code_next       = error_code;
    bus_reset_next  = 1'b0;
    go_err          = 1'b0;
    go_code         = ERR_STUFF;

    // Saturating SE0 run length; the strobe fires only on the exact count
    if (cls != C_SE0)           se0_cnt_next = '0;
    else if (se0_cnt != SE0_SAT) se0_cnt_next = se0_cnt + SE0_W'(1);
    else                         se0_cnt_next = se0_cnt;

    case (state)
      S_IDLE: begin
        if (hist_next == SYNC_PAT) begin
          state_next      = S_DATA;
          prev_k_next     = 1'b1;
          ones_next       = '0;
          bit_cnt_next    = '0;
          byte_cnt_next   = '0;
          held_valid_next = 1'b0;
        end
      end

      S_DATA: begin
        if (cls == C_SE0) begin
          state_next   = S_EOP;
          eop_cnt_next = 2'd1;
        end else if (cls == C_BAD) begin
          go_err  = 1'b1;
          go_code = ERR_SE1;
        end else begin
          prev_k_next = (cls == C_K);
          if (ones == 3'd6) begin
            // Stuff position: a zero is dropped, a one is a stuff error
            if (rx_bit) begin
              go_err  = 1'b1;
              go_code = ERR_STUFF;
            end else begin
              ones_next = '0;
            end
          end else begin
            ones_next  = rx_bit ? ones + 3'd1 : 3'd0;
            shift_next = new_byte;
            if (bit_cnt == 3'd7) begin
              bit_cnt_next = '0;
              if (byte_cnt == BYTE_MAX) begin
                go_err  = 1'b1;
                go_code = ERR_BABBLE;
              end else begin
                // One-byte holding stage so the final byte can carry "last"
                held_next       = new_byte;
                held_valid_next = 1'b1;
                byte_cnt_next   = byte_cnt + BYTE_W'(1);
                if (held_valid) begin
                  data_out_next = held;
                  val_next      = 1'b1;
                end
              end
            end else begin
              bit_cnt_next = bit_cnt + 3'd1;
            end
          end
        end
      end

      S_EOP: begin
        case (cls)
          C_SE0: begin
            if (eop_cnt == 2'd1) begin
              eop_cnt_next = 2'd2;
            end else begin
              // Third SE0: the alignment error is only reported if the run
              // ends short of a bus reset, so a reset never carries rx_error.
              state_next      = S_ERROR;
              held_valid_next = 1'b0;
              idle_cnt_next   = '0;
              pend_err_next   = 1'b1;
            end
          end
          C_J: begin
            state_next      = S_IDLE;
            held_valid_next = 1'b0;
            if (held_valid) begin
              data_out_next = held;
              val_next      = 1'b1;
              last_next     = 1'b1;
            end
            if (bit_cnt != 3'd0) begin
              err_next  = 1'b1;
              code_next = ERR_ALIGN;
            end
          end
          C_K: begin
            go_err  = 1'b1;
            go_code = ERR_ALIGN;
          end
          default: begin
            go_err  = 1'b1;
            go_code = ERR_SE1;
          end
        endcase
      end

      S_ERROR: begin
        if (cls == C_J) begin
          if (idle_cnt == IDLE_LAST) begin
            state_next    = S_IDLE;
            idle_cnt_next = '0;
          end else begin
            idle_cnt_next = idle_cnt + IDLE_W'(1);
          end
        end else begin
          idle_cnt_next = '0;
        end
        if (pend_err && (cls != C_SE0)) begin
          err_next      = 1'b1;
          code_next     = ERR_ALIGN;
          pend_err_next = 1'b0;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Errors are only raised from non-ERROR states, so only the first
    // error of a packet ever strobes.
    if (go_err) begin
      state_next      = S_ERROR;
      held_valid_next = 1'b0;
      idle_cnt_next   = '0;
      err_next        = 1'b1;
      code_next       = go_code;
    end

    if (reset_hit) begin
      state_next      = S_IDLE;
      held_valid_next = 1'b0;
      pend_err_next   = 1'b0;
      val_next        = 1'b0;
      last_next       = 1'b0;
      err_next        = 1'b0;
      bus_reset_next  = 1'b1;
    end

    if (!rx_enable) begin
      state_next      = S_IDLE;
      held_valid_next = 1'b0;
      pend_err_next   = 1'b0;
      val_next        = 1'b0;
      last_next       = 1'b0;
      err_next        = 1'b0;
      bus_reset_next  = 1'b0;
      hist_next       = '0;
      se0_cnt_next    = '0;
    end

    active_next = (state_next == S_DATA) || (state_next == S_EOP);
  end

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// tb_usb_rx_packet_decoder
//  Drives NRZI/bit-stuffed packets into usb_rx_packet_decoder (MAX_BYTES=4)
//  from a table of packet records, plus hand-written sequences for stuff
//  errors, ERROR recovery, bus reset, SYNC restart, SE1 and rx_enable abort.
//  Expected bytes and error codes are queued before stimulus and popped by a
//  monitor when the DUT strobes.
module tb_usb_rx_packet_decoder;

  logic       clock;
  logic       reset_n;
  logic [1:0] J_state;
  logic [1:0] K_state;
  logic [1:0] usb_signals;
  logic       rx_enable;
  logic [7:0] data_out;
  logic       data_out_val;
  logic       data_out_last;
  logic       rx_active;
  logic       rx_error;
  logic [1:0] error_code;
  logic       bus_reset_det;

  usb_rx_packet_decoder #(
    .RESET_CYCLES(16),
    .IDLE_CYCLES (7),
    .MAX_BYTES   (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .J_state      (J_state),
    .K_state      (K_state),
    .usb_signals  (usb_signals),
    .rx_enable    (rx_enable),
    .data_out     (data_out),
    .data_out_val (data_out_val),
    .data_out_last(data_out_last),
    .rx_active    (rx_active),
    .rx_error     (rx_error),
    .error_code   (error_code),
    .bus_reset_det(bus_reset_det)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;

  typedef struct packed { logic [7:0] data; logic last; } exp_t;
  typedef struct packed { logic [1:0] code; logic with_last; } err_t;
  exp_t exp_q[$];
  err_t err_q[$];

  typedef struct {
    int              nbytes;
    logic [4:0][7:0] b;
    int              nx;
    logic [7:0]      xbits;
    bit              low_speed;
    int              nval;
    bit              last_ok;
    int              err;
    bit              err_last;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];

  // Encoder state: current line level and run of ones for stuffing
  logic lvl_k;
  int   ones;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                              input int nx, input logic [7:0] xb, input bit ls,
                              input int nval, input bit last_ok, input int err, input bit el);
    vec_t v;
    v.nbytes = nb;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.nx = nx; v.xbits = xb; v.low_speed = ls;
    v.nval = nval; v.last_ok = last_ok; v.err = err; v.err_last = el;
    return v;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c, input logic wl);
    err_t e;
    e.code = c;
    e.with_last = wl;
    err_q.push_back(e);
  endtask

  // Called at a negedge; returns at the next negedge with the DUT's
  // response to this symbol visible on the outputs.
  task automatic send_sym(input logic [1:0] s);
    usb_signals = s;
    @(negedge clock);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_sym(J_state);
  endtask

  task automatic send_sync();
    send_sym(K_state); send_sym(J_state); send_sym(K_state); send_sym(J_state);
    send_sym(K_state); send_sym(J_state); send_sym(K_state); send_sym(K_state);
    lvl_k = 1'b1;
    ones  = 0;
  endtask

  task automatic send_bit(input logic b, input bit stuff_en);
    if (!b) lvl_k = ~lvl_k;
    send_sym(lvl_k ? K_state : J_state);
    ones = b ? ones + 1 : 0;
    if (stuff_en && ones == 6) begin
      lvl_k = ~lvl_k;
      send_sym(lvl_k ? K_state : J_state);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b1);
  endtask

  task automatic send_eop();
    send_sym(2'b00);
    send_sym(2'b00);
    send_sym(J_state);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (data_out_val) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_val: got data=%0h last=%0b required no strobe", data_out, data_out_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_out", {24'd0, data_out}, {24'd0, e.data});
          chk("data_out_last", {31'd0, data_out_last}, {31'd0, e.last});
        end
      end
      if (rx_error) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rx_error: got code=%0d required no strobe", error_code);
        end else begin
          err_t e;
          e = err_q.pop_front();
          chk("error_code", {30'd0, error_code}, {30'd0, e.code});
          if (e.with_last)
            chk("err_with_last", {31'd0, data_out_val & data_out_last}, 32'd1);
        end
      end
      if (bus_reset_det) rst_pulses++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    reset_n     = 1'b0;
    J_state     = 2'b10;
    K_state     = 2'b01;
    usb_signals = 2'b10;
    rx_enable   = 1'b1;
    lvl_k       = 1'b0;
    ones        = 0;

    tbl[0] = mk(3, 8'h2D, 8'h00, 8'h10, 8'h00, 8'h00, 0, 8'h00, 0, 3, 1, -1, 0);
    tbl[1] = mk(2, 8'hFF, 8'h3F, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 2, 1, -1, 0);
    tbl[2] = mk(1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h05, 0, 1, 1,  2, 1);
    tbl[3] = mk(5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 0, 8'h00, 0, 3, 0,  3, 0);
    tbl[4] = mk(1, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1, 1, 1, -1, 0);
    tbl[5] = mk(4, 8'h96, 8'h7F, 8'h00, 8'hE1, 8'h00, 0, 8'h00, 0, 4, 1, -1, 0);

    repeat (3) @(negedge clock);
    chk("reset data_out",      {24'd0, data_out},      32'd0);
    chk("reset data_out_val",  {31'd0, data_out_val},  32'd0);
    chk("reset data_out_last", {31'd0, data_out_last}, 32'd0);
    chk("reset rx_active",     {31'd0, rx_active},     32'd0);
    chk("reset rx_error",      {31'd0, rx_error},      32'd0);
    chk("reset error_code",    {30'd0, error_code},    32'd0);
    chk("reset bus_reset_det", {31'd0, bus_reset_det}, 32'd0);
    reset_n = 1'b1;
    send_idle(4);

    // Table-driven packets
    for (int t = 0; t < NV; t++) begin
      v = tbl[t];
      J_state = v.low_speed ? 2'b01 : 2'b10;
      K_state = v.low_speed ? 2'b10 : 2'b01;
      send_idle(4);
      for (int i = 0; i < v.nval; i++)
        push_byte(v.b[i], v.last_ok && (i == v.nval - 1));
      if (v.err >= 0) push_err(2'(v.err), v.err_last);
      send_sync();
      chk("sync rx_active", {31'd0, rx_active}, 32'd1);
      for (int i = 0; i < v.nbytes; i++) send_byte(v.b[i]);
      for (int i = 0; i < v.nx; i++) send_bit(v.xbits[i], 1'b1);
      send_eop();
      chk("post eop rx_active", {31'd0, rx_active}, 32'd0);
      send_idle(10);
    end
    J_state = 2'b10;
    K_state = 2'b01;
    send_idle(4);

    // Seven ones without a transition: stuff error, then six J are not enough
    send_sync();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    chk("six ones rx_active", {31'd0, rx_active}, 32'd1);
    push_err(2'd0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("stuff err rx_active", {31'd0, rx_active}, 32'd0);
    send_idle(6);
    send_sync();                 // must be ignored: still in ERROR
    chk("error holds rx_active", {31'd0, rx_active}, 32'd0);
    send_byte(8'h00);
    send_eop();
    send_idle(10);

    // SE0 held 20 clocks inside DATA: bus reset at the 16th, no rx_error
    send_sync();
    send_byte(8'h55);
    for (int i = 1; i <= 20; i++) begin
      send_sym(2'b00);
      if (i == 15) chk("se0 15 bus_reset_det", {31'd0, bus_reset_det}, 32'd0);
      if (i == 16) chk("se0 16 bus_reset_det", {31'd0, bus_reset_det}, 32'd1);
      if (i == 17) chk("se0 17 bus_reset_det", {31'd0, bus_reset_det}, 32'd0);
    end
    chk("bus reset rx_active", {31'd0, rx_active}, 32'd0);
    send_idle(10);
    chk("bus reset pulses", rst_pulses, 32'd1);

    // Partial SYNC broken by SE0 / SE1 restarts the hunt silently
    send_sym(K_state); send_sym(J_state); send_sym(K_state); send_sym(J_state);
    send_sym(2'b00);
    send_sym(K_state); send_sym(J_state); send_sym(K_state); send_sym(2'b11);
    send_idle(2);
    push_byte(8'h3C, 1'b1);
    send_sync();
    send_byte(8'h3C);
    send_eop();
    send_idle(10);

    // SE1 inside DATA
    push_err(2'd1, 1'b0);
    send_sync();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    send_sym(2'b11);
    chk("se1 rx_active", {31'd0, rx_active}, 32'd0);
    send_idle(10);

    // rx_enable low mid-packet: silent abort, held byte 0x22 never appears
    push_byte(8'h11, 1'b0);
    send_sync();
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    rx_enable = 1'b0;
    send_idle(1);
    chk("abort rx_active", {31'd0, rx_active}, 32'd0);
    send_idle(2);
    rx_enable = 1'b1;
    send_idle(10);

    // Clean packet after everything
    push_byte(8'h7E, 1'b1);
    send_sync();
    send_byte(8'h7E);
    send_eop();
    send_idle(10);

    chk("pending bytes", exp_q.size(), 32'd0);
    chk("pending errors", err_q.size(), 32'd0);
    chk("final bus reset pulses", rst_pulses, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
